// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles little-endian words from a framed image,
// writes them into instruction memory, verifies an XOR checksum and releases the core.
module imem_program_loader #(
    parameter int          PC_SIZE        = 10,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  START_BYTE     = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_rw,
    output logic [PC_SIZE-1:0] imem_addr,
    output logic [31:0]        imem_data,
    output logic               imem_clear,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [PC_SIZE:0]   words_loaded
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLEAR  = 4'd1,
        LEN_LO = 4'd2,
        LEN_HI = 4'd3,
        DATA   = 4'd4,
        WRITE  = 4'd5,
        CHECK  = 4'd6,
        DONE   = 4'd7,
        ERROR  = 4'd8
    } state_t;

    localparam int           TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]  MAX_WORDS = 17'd1 << PC_SIZE;

    // Word count must be non-zero and fit the instruction memory.
    function automatic logic len_bad(input logic [15:0] n);
        return (n == 16'd0) || ({1'b0, n} > MAX_WORDS);
    endfunction

    state_t               state_r;
    state_t               next_s;
    logic                 byte_ready_r;
    logic                 imem_rw_r;
    logic                 imem_clear_r;
    logic                 core_reset_r;
    logic                 load_done_r;
    logic                 load_error_r;
    logic [15:0]          len_r;
    logic [1:0]           byte_idx_r;
    logic [PC_SIZE-1:0]   addr_r;
    logic [31:0]          data_r;
    logic [PC_SIZE:0]     words_r;
    logic [7:0]           csum_r;
    logic [TW-1:0]        tmo_r;
    logic                 fire_s;
    logic                 waiting_s;
    logic                 tmo_hit_s;
    logic [PC_SIZE:0]     words_next_s;

    assign fire_s       = byte_valid && byte_ready_r;
    assign waiting_s    = (state_r == LEN_LO) || (state_r == LEN_HI) ||
                          (state_r == DATA)   || (state_r == CHECK);
    assign tmo_hit_s    = (tmo_r == TMO_LAST);
    assign words_next_s = words_r + {{PC_SIZE{1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fire_s && (byte_in == START_BYTE)) next_s = CLEAR;
                else                                   next_s = IDLE;
            end
            CLEAR: next_s = LEN_LO;
            LEN_LO: begin
                if (fire_s)         next_s = LEN_HI;
                else if (tmo_hit_s) next_s = ERROR;
                else                next_s = LEN_LO;
            end
            LEN_HI: begin
                if (fire_s) begin
                    if (len_bad({byte_in, len_r[7:0]})) next_s = ERROR;
                    else                                next_s = DATA;
                end else if (tmo_hit_s) begin
                    next_s = ERROR;
                end else begin
                    next_s = LEN_HI;
                end
            end
            DATA: begin
                if (fire_s) begin
                    if (byte_idx_r == 2'd3) next_s = WRITE;
                    else                    next_s = DATA;
                end else if (tmo_hit_s) begin
                    next_s = ERROR;
                end else begin
                    next_s = DATA;
                end
            end
            WRITE: begin
                if (17'(words_next_s) == {1'b0, len_r}) next_s = CHECK;
                else                                     next_s = DATA;
            end
            CHECK: begin
                if (fire_s) begin
                    if (byte_in == csum_r) next_s = DONE;
                    else                   next_s = ERROR;
                end else if (tmo_hit_s) begin
                    next_s = ERROR;
                end else begin
                    next_s = CHECK;
                end
            end
            DONE:    next_s = IDLE;
            ERROR:   next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Idle-cycle timer; restarts on every accepted byte and on each state change.
    always_ff @(posedge clock) begin
        if (reset || fire_s || (next_s != state_r) || !waiting_s) begin
            tmo_r <= '0;
        end else begin
            tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Datapath and registered outputs, decoded from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_ready_r <= 1'b0;
            imem_rw_r    <= 1'b0;
            imem_clear_r <= 1'b0;
            core_reset_r <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
            len_r        <= 16'd0;
            byte_idx_r   <= 2'd0;
            addr_r       <= '0;
            data_r       <= 32'd0;
            words_r      <= '0;
            csum_r       <= 8'd0;
        end else begin
            byte_ready_r <= (next_s == IDLE) || (next_s == LEN_LO) || (next_s == LEN_HI) ||
                            (next_s == DATA) || (next_s == CHECK);
            imem_rw_r    <= (next_s == WRITE);
            imem_clear_r <= (next_s == CLEAR);
            load_done_r  <= (next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (fire_s && (byte_in == START_BYTE)) begin
                        core_reset_r <= 1'b1;
                        load_error_r <= 1'b0;
                        words_r      <= '0;
                        csum_r       <= 8'd0;
                    end
                end
                LEN_LO: if (fire_s) len_r[7:0] <= byte_in;
                LEN_HI: begin
                    if (fire_s) begin
                        len_r[15:8] <= byte_in;
                        byte_idx_r  <= 2'd0;
                        addr_r      <= '0;
                    end
                end
                DATA: begin
                    if (fire_s) begin
                        data_r[{byte_idx_r, 3'b000} +: 8] <= byte_in;
                        csum_r     <= csum_r ^ byte_in;
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                end
                WRITE: begin
                    words_r <= words_next_s;
                    addr_r  <= addr_r + {{(PC_SIZE-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
            if (next_s == ERROR) load_error_r <= 1'b1;
            if (next_s == DONE)  core_reset_r <= 1'b0;
        end
    end

    assign byte_ready   = byte_ready_r;
    assign imem_rw      = imem_rw_r;
    assign imem_addr    = addr_r;
    assign imem_data    = data_r;
    assign imem_clear   = imem_clear_r;
    assign core_reset   = core_reset_r;
    assign load_done    = load_done_r;
    assign load_error   = load_error_r;
    assign words_loaded = words_r;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: stimulus queues expected clear/write/done
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_program_loader;

    localparam int PC = 10;
    localparam int EV_CLR = 0;
    localparam int EV_WR  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          imem_rw;
    logic [PC-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          imem_clear;
    logic          core_reset;
    logic          load_done;
    logic          load_error;
    logic [PC:0]   words_loaded;

    int  tests = 0;
    int  fails = 0;
    ev_t q[$];

    imem_program_loader #(.PC_SIZE(PC), .TIMEOUT_CYCLES(16), .START_BYTE(8'hA5)) dut (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .imem_rw(imem_rw), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_clear(imem_clear), .core_reset(core_reset),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none", kind, addr, data);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == EV_WR) begin
                chk("write_addr", addr, e.addr);
                chk("write_data", data, e.data);
            end
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_rw && imem_clear) begin
                tests++; fails++;
                $display("FAIL rw_clear_overlap: got both high expected exclusive");
            end
            if (imem_clear) pop_cmp(EV_CLR, 32'd0, 32'd0);
            if (imem_rw)    pop_cmp(EV_WR, 32'(imem_addr), imem_data);
            if (load_done) begin
                pop_cmp(EV_DONE, 32'd0, 32'd0);
                chk("core_reset_with_done", 32'(core_reset), 32'd0);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL byte_ready_wait: got no ready expected ready within 100 cycles");
        end
        @(posedge clock); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic settle(input string name);
        repeat (3) begin @(posedge clock); #1; end
        chk({name, "_queue_drained"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_imem_rw", 32'(imem_rw), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_data", imem_data, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;

        // 1: two-word frame with correct checksum
        push(EV_CLR, 0, 0); push(EV_WR, 0, 32'h13); push(EV_WR, 1, 32'hB3); push(EV_DONE, 0, 0);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'hA0});
        settle("t1");
        chk("t1_core_reset", 32'(core_reset), 32'd0);
        chk("t1_words", 32'(words_loaded), 32'd2);
        chk("t1_load_error", 32'(load_error), 32'd0);

        // 2: bad checksum, then a good frame clears the error
        push(EV_CLR, 0, 0);
        send_byte(8'hA5);
        chk("t2_core_reset_on_start", 32'(core_reset), 32'd1);
        push(EV_WR, 0, 32'h13); push(EV_WR, 1, 32'hB3);
        send_seq('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h00});
        chk("t2_error_after_bad_sum", 32'(load_error), 32'd1);
        settle("t2a");
        chk("t2_error_sticky", 32'(load_error), 32'd1);
        chk("t2_core_held", 32'(core_reset), 32'd1);
        push(EV_CLR, 0, 0);
        send_byte(8'hA5);
        chk("t2_error_cleared", 32'(load_error), 32'd0);
        push(EV_WR, 0, 32'h13); push(EV_WR, 1, 32'hB3); push(EV_DONE, 0, 0);
        send_seq('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'hA0});
        settle("t2b");
        chk("t2_core_released", 32'(core_reset), 32'd0);

        // 3: illegal lengths
        push(EV_CLR, 0, 0);
        send_seq('{8'hA5, 8'h00, 8'h00});
        chk("t3_len0_error", 32'(load_error), 32'd1);
        settle("t3a");
        push(EV_CLR, 0, 0);
        send_seq('{8'hA5, 8'h01, 8'h04});
        chk("t3_len1025_error", 32'(load_error), 32'd1);
        settle("t3b");
        chk("t3_words", 32'(words_loaded), 32'd0);

        // 4: leading garbage discarded, then one-word frame
        send_seq('{8'h00, 8'hFF, 8'h12});
        settle("t4a");
        push(EV_CLR, 0, 0); push(EV_WR, 0, 32'h12345678); push(EV_DONE, 0, 0);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        settle("t4b");
        chk("t4_words", 32'(words_loaded), 32'd1);
        chk("t4_load_error", 32'(load_error), 32'd0);

        // 5a: stall 16 cycles mid-frame
        push(EV_CLR, 0, 0);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h11});
        repeat (15) begin @(posedge clock); #1; end
        chk("t5_no_early_timeout", 32'(load_error), 32'd0);
        @(posedge clock); #1;
        chk("t5_timeout_error", 32'(load_error), 32'd1);
        settle("t5a");

        // 5b: byte held during WRITE; START byte mid-frame is data
        push(EV_CLR, 0, 0); push(EV_WR, 0, 32'h000000A5); push(EV_WR, 1, 32'h04030201);
        push(EV_DONE, 0, 0);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00});
        byte_in = 8'h01;
        byte_valid = 1'b1;
        chk("t5_rw_in_write", 32'(imem_rw), 32'd1);
        chk("t5_ready_low_in_write", 32'(byte_ready), 32'd0);
        send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1});
        settle("t5b");
        chk("t5_words", 32'(words_loaded), 32'd2);

        // 6: reset mid-frame, then reload from address 0
        push(EV_CLR, 0, 0);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_rst_ready", 32'(byte_ready), 32'd0);
        chk("t6_rst_addr", 32'(imem_addr), 32'd0);
        chk("t6_rst_data", imem_data, 32'd0);
        chk("t6_rst_core_reset", 32'(core_reset), 32'd1);
        chk("t6_rst_words", 32'(words_loaded), 32'd0);
        chk("t6_rst_error", 32'(load_error), 32'd0);
        reset = 1'b0;
        chk("t6_queue_after_reset", 32'(q.size()), 32'd0);
        push(EV_CLR, 0, 0); push(EV_WR, 0, 32'hDEADBEEF); push(EV_DONE, 0, 0);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22});
        settle("t6");
        chk("t6_core_released", 32'(core_reset), 32'd0);
        chk("t6_words", 32'(words_loaded), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Byte-stream program loader that drives the instruction-memory write port of the RISC_V core.
- Receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit instructions.
- Clears instruction memory, writes each word to consecutive addresses, verifies an XOR checksum, then releases the core from reset.
- Sits between a host link (UART RX or testbench) and the core's program-load inputs.

Parameters:
- PC_SIZE, 10, width of the instruction-memory address; matches the core.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes mid-frame before error; must be ≥ 1.
- START_BYTE, 8'hA5, frame start marker.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader can accept a byte; transfer occurs when byte_valid && byte_ready.
- imem_rw  out  1  1 = write instruction memory this cycle.
- imem_addr  out  PC_SIZE  write address.
- imem_data  out  32  instruction word.
- imem_clear  out  1  one-cycle instruction-memory clear pulse.
- core_reset  out  1  holds the core in reset while high.
- load_done  out  1  one-cycle pulse on successful load.
- load_error  out  1  sticky error flag.
- words_loaded  out  PC_SIZE+1  count of words written in the current or last frame.

Behaviour:
- Reset values:
  - byte_ready=0, imem_rw=0, imem_addr=0, imem_data=0, imem_clear=0, load_done=0, load_error=0, words_loaded=0.
  - core_reset=1. The core does not run until a successful load.
- FSM states: IDLE, CLEAR, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR. The cycle after reset deasserts, the FSM is in IDLE.
- IDLE:
  - byte_ready=1.
  - Accepted bytes other than START_BYTE are discarded.
  - START_BYTE → CLEAR. Also sets core_reset=1, clears load_error, words_loaded, and the checksum accumulator.
- CLEAR:
  - byte_ready=0.
  - imem_clear=1 for exactly this one cycle.
  - → LEN_LO.
- LEN_LO / LEN_HI:
  - byte_ready=1.
  - Capture the 16-bit word count N, low byte first.
  - After LEN_HI: if N==0 or N > 2^PC_SIZE → ERROR; otherwise → DATA with byte index 0 and address 0.
- DATA:
  - byte_ready=1.
  - Byte k (0..3) goes into imem_data[8k+7:8k]; each accepted byte is XORed into the checksum.
  - The 4th accepted byte → WRITE.
- WRITE:
  - byte_ready=0.
  - imem_rw=1 for exactly one cycle, with imem_addr = current word index and imem_data = the assembled word.
  - Next cycle: words_loaded increments, address increments.
  - If words_loaded (new) == N → CHECK; otherwise → DATA.
  - Latency: imem_rw asserts in the cycle after the 4th byte is accepted.
- CHECK:
  - byte_ready=1.
  - Accept one byte. If it equals the accumulated XOR → DONE; otherwise → ERROR.
- DONE:
  - byte_ready=0.
  - load_done=1 for one cycle; core_reset goes 0 in the same cycle.
  - → IDLE.
- ERROR:
  - byte_ready=0 for one cycle, load_error=1 (sticky), core_reset stays 1.
  - → IDLE. A new START_BYTE restarts the load and clears load_error.
- Timeout:
  - Applies in LEN_LO, LEN_HI, DATA and CHECK.
  - The counter resets on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES cycles with no accepted byte → ERROR.
- Flow control: byte_valid is ignored while byte_ready=0. The byte is not consumed, so the source must hold it.
- Boundaries:
  - Address wraps never occur, since N ≤ 2^PC_SIZE is enforced; the last address written is N-1.
  - imem_rw and imem_clear are never high in the same cycle.
  - START_BYTE appearing mid-frame is treated as ordinary data.
  - Reset mid-frame: immediate return to reset values. Already-written words are left in memory.
  - After load_done, core_reset stays 0 until the next START_BYTE is accepted.

Test Plan:
1. Reset, then send A5, 02, 00, then bytes 13 00 00 00 and B3 00 00 00, then checksum A0 → imem_clear pulses once; writes 0x00000013@0 and 0x000000B3@1, each with imem_rw high for one cycle; load_done pulses; core_reset falls; words_loaded=2.
2. Same frame with checksum 00 → no load_done; load_error=1; core_reset stays 1; then a correct frame clears load_error and completes.
3. Send A5, 00, 00 → ERROR with no imem_rw. Send A5, 01, 04 (N=1025 with PC_SIZE=10) → ERROR.
4. Leading garbage 00 FF 12 before A5 → discarded with no writes; then a normal 1-word frame loads at address 0.
5. TIMEOUT_CYCLES=16: send A5, 01, 00, 11 and then stall 16 cycles → load_error=1. Assert byte_valid during a WRITE cycle → byte not consumed, byte_ready=0.
6. Assert reset after 2 of 4 data bytes → all outputs return to reset values and core_reset=1. The next frame loads from address 0 correctly.
